// File: rtl/datapath_pkg.sv
// ---------------------------------------------------------------------------
// datapath_pkg
//   Shared widths and the ALU operation encoding for the integer datapath.
//   XLEN    : data width of registers and the ALU
//   NREGS   : number of architectural registers (x0..x31)
//   REG_AW  : register address width
//   alu_op_e: 3-bit ALU operation select driven by the CPU controller
// ---------------------------------------------------------------------------
package datapath_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    // Only the low five bits of operand B form a shift amount; the rest of
    // the operand is ignored for SLL/SRL.
    function automatic logic [4:0] shamt(input logic [XLEN-1:0] b);
        return b[4:0];
    endfunction

endpackage

// File: rtl/register_bank.sv
// ---------------------------------------------------------------------------
// register_bank
//   32 x 32-bit integer register file with one synchronous write port and
//   two asynchronous read ports. x0 always reads zero and ignores writes.
//
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset, clears every register;
//                   wins over a write on the same edge
//   write_en   in   write strobe
//   rd_addr    in   write address
//   wdata      in   write data
//   rs_1       in   read address, port 1
//   rs_2       in   read address, port 2
//   readdata_1 out  regs[rs_1] (combinational)
//   readdata_2 out  regs[rs_2] (combinational)
// ---------------------------------------------------------------------------
module register_bank
    import datapath_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              write_en,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] rs_1,
    input  logic [REG_AW-1:0] rs_2,
    output logic [XLEN-1:0]   readdata_1,
    output logic [XLEN-1:0]   readdata_2
);

    logic [XLEN-1:0] regs [NREGS];

    // Entry 0 is still stored and cleared by reset, but it is never written
    // and the read mux forces zero for address 0 regardless of its content.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en && (rd_addr != '0)) begin
            regs[rd_addr] <= wdata;
        end
    end

    // No write-to-read bypass: a write becomes visible after its edge.
    always_comb begin
        readdata_1 = '0;
        readdata_2 = '0;
        if (rs_1 != '0) readdata_1 = regs[rs_1];
        if (rs_2 != '0) readdata_2 = regs[rs_2];
    end

endmodule

// File: rtl/datapath.sv
// ---------------------------------------------------------------------------
// datapath
//   RISC-V integer datapath core: register file plus a combinational ALU.
//   Operand A is regs[rs_1], operand B is regs[rs_2]; externally supplied
//   writedata is written to rd_0 when write_rb is high.
//
//   clk          in   rising-edge clock
//   rst_n        in   synchronous reset, ACTIVE-HIGH despite the name
//   write_rb     in   register-bank write enable
//   alu_control  in   ALU operation select (alu_op_e encoding)
//   rs_1         in   source register 1 address (operand A)
//   rs_2         in   source register 2 address (operand B)
//   rd_0         in   destination register address
//   writedata    in   data written to rd_0
//   alu_result   out  combinational ALU result, wraps modulo 2^32
// ---------------------------------------------------------------------------
module datapath
    import datapath_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write_rb,
    input  logic [2:0]        alu_control,
    input  logic [REG_AW-1:0] rs_1,
    input  logic [REG_AW-1:0] rs_2,
    input  logic [REG_AW-1:0] rd_0,
    input  logic [XLEN-1:0]   writedata,
    output logic [XLEN-1:0]   alu_result
);

    logic [XLEN-1:0] readdata_1;
    logic [XLEN-1:0] readdata_2;
    alu_op_e         alu_op;

    register_bank REGISTER_BANK (
        .clk        (clk),
        .rst        (rst_n),
        .write_en   (write_rb),
        .rd_addr    (rd_0),
        .wdata      (writedata),
        .rs_1       (rs_1),
        .rs_2       (rs_2),
        .readdata_1 (readdata_1),
        .readdata_2 (readdata_2)
    );

    // Every 3-bit code maps to an enum member, so the cast is total.
    assign alu_op = alu_op_e'(alu_control);

    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD: alu_result = readdata_1 + readdata_2;
            ALU_SUB: alu_result = readdata_1 - readdata_2;
            ALU_AND: alu_result = readdata_1 & readdata_2;
            ALU_OR:  alu_result = readdata_1 | readdata_2;
            ALU_XOR: alu_result = readdata_1 ^ readdata_2;
            ALU_SLL: alu_result = readdata_1 << shamt(readdata_2);
            ALU_SRL: alu_result = readdata_1 >> shamt(readdata_2);
            // Signed compare; result is 0 or 1 zero-extended to XLEN.
            ALU_SLT: alu_result = ($signed(readdata_1) < $signed(readdata_2))
                                  ? XLEN'(1) : '0;
            default: alu_result = '0;
        endcase
    end

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;
    import datapath_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        write_rb = 1'b0;
    logic [2:0]  alu_control = 3'b000;
    logic [4:0]  rs_1 = '0;
    logic [4:0]  rs_2 = '0;
    logic [4:0]  rd_0 = '0;
    logic [31:0] writedata = '0;
    logic [31:0] alu_result;

    always #5 clk = ~clk;

    datapath dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .write_rb    (write_rb),
        .alu_control (alu_control),
        .rs_1        (rs_1),
        .rs_2        (rs_2),
        .rd_0        (rd_0),
        .writedata   (writedata),
        .alu_result  (alu_result)
    );

    // ---------------- scoreboard ----------------
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] alu_exp [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Reset edge, optionally with a simultaneous write request.
    task automatic do_reset(input logic we, input logic [4:0] rd, input logic [31:0] d);
        @(negedge clk);
        rst_n = 1'b1; write_rb = we; rd_0 = rd; writedata = d;
        @(posedge clk);
        #1;
        rst_n = 1'b0; write_rb = 1'b0;
    endtask

    task automatic write_reg(input logic [4:0] rd, input logic [31:0] d);
        @(negedge clk);
        rd_0 = rd; writedata = d; write_rb = 1'b1;
        @(posedge clk);
        #1;
        write_rb = 1'b0;
    endtask

    task automatic set_read(input logic [4:0] a, input logic [4:0] b, input logic [2:0] op);
        rs_1 = a; rs_2 = b; alu_control = op;
        #1;
    endtask

    task automatic check_alu(input string tag, input logic [4:0] a, input logic [4:0] b,
                             input logic [2:0] op, input logic [31:0] exp);
        set_read(a, b, op);
        check(tag, alu_result, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        alu_exp = '{32'd10, 32'd4, 32'd3, 32'd7, 32'd4, 32'd56, 32'd0, 32'd0};

        // Reset clears every register; ADD of zeros is zero.
        do_reset(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 32; i++) begin
            set_read(5'(i), 5'd0, 3'b000);
            check($sformatf("rst_rd1_x%0d", i), dut.REGISTER_BANK.readdata_1, 32'd0);
            check($sformatf("rst_add_x%0d", i), alu_result, 32'd0);
        end

        // Write sweep; x0 must stay zero.
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back((i == 0) ? 32'd0 : 32'((i + 1) * 2));
            write_reg(5'(i), 32'((i + 1) * 2));
            set_read(5'(i), 5'd0, 3'b000);
            check($sformatf("sweep_x%0d", i), dut.REGISTER_BANK.readdata_1, exp_q.pop_front());
        end

        // Write not enabled: x5 keeps 12.
        @(negedge clk);
        rd_0 = 5'd5; writedata = 32'hDEADBEEF; write_rb = 1'b0;
        @(posedge clk);
        #1;
        set_read(5'd5, 5'd0, 3'b000);
        check("no_we_x5", dut.REGISTER_BANK.readdata_1, 32'd12);

        // ALU op table with x1=7, x2=3.
        write_reg(5'd1, 32'd7);
        write_reg(5'd2, 32'd3);
        for (int op = 0; op < 8; op++) begin
            check_alu($sformatf("alu_op%0d", op), 5'd1, 5'd2, 3'(op), alu_exp[op]);
        end

        // Shift amount uses only B[4:0]: x6=33 -> shift by 1.
        write_reg(5'd6, 32'd33);
        check_alu("sll_mask", 5'd1, 5'd6, 3'b101, 32'd14);
        check_alu("srl_mask", 5'd1, 5'd6, 3'b110, 32'd3);

        // Negative operand A.
        write_reg(5'd1, 32'hFFFFFFFF);
        check_alu("slt_neg",   5'd1, 5'd2, 3'b111, 32'd1);
        check_alu("add_wrap",  5'd1, 5'd2, 3'b000, 32'd2);
        check_alu("sub_neg_b", 5'd2, 5'd1, 3'b001, 32'd4);
        check_alu("slt_rev",   5'd2, 5'd1, 3'b111, 32'd0);
        check_alu("srl_logic", 5'd1, 5'd6, 3'b110, 32'h7FFFFFFF);

        // Reset wins over a simultaneous write; whole bank cleared.
        do_reset(1'b1, 5'd7, 32'h00001234);
        set_read(5'd7, 5'd0, 3'b000);
        check("collide_x7", dut.REGISTER_BANK.readdata_1, 32'd0);
        set_read(5'd5, 5'd0, 3'b000);
        check("collide_x5", dut.REGISTER_BANK.readdata_1, 32'd0);

        // No bypass: the pending write is invisible until its edge.
        @(negedge clk);
        rd_0 = 5'd10; writedata = 32'h00000ABC; write_rb = 1'b1;
        set_read(5'd10, 5'd0, 3'b000);
        check("no_bypass", dut.REGISTER_BANK.readdata_1, 32'd0);
        @(posedge clk);
        #1;
        write_rb = 1'b0;
        set_read(5'd10, 5'd0, 3'b000);
        check("after_edge", dut.REGISTER_BANK.readdata_1, 32'h00000ABC);

        // Dual read of the same register.
        write_reg(5'd4, 32'd9);
        check_alu("dual_add", 5'd4, 5'd4, 3'b000, 32'd18);
        check_alu("dual_sub", 5'd4, 5'd4, 3'b001, 32'd0);

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
